wb_stage: RTL and testbench

//  Write-back stage of the 5-stage MIPS pipeline; drives the decode stage's register-file write port (we/waddr/wdata).

---
 rtl/wb_stage_pkg.sv | 8 +
 rtl/wb_timer.sv | 19 +
 rtl/wb_stage.sv | 87 ++++++++
 tb/tb_wb_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared bus widths and write-back state codes
package wb_stage_pkg;
  localparam int REG_BUS = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int INST_ADDR_BUS = 32;
  localparam int WB_TIMEOUT = 16;
  typedef enum logic {WB_IDLE = 1'b0, WB_WAIT = 1'b1} wb_state_e;
endpackage

// File: rtl/wb_timer.sv
// wb_timer: counts enabled cycles from clear, flags the cycle the count reaches LIMIT-1 (LIMIT=0 never expires)
module wb_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int W = LIMIT > 1 ? $clog2(LIMIT) : 1;
  logic [W-1:0] count;
  assign expired = LIMIT != 0 && int'(count) == LIMIT - 1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else if (clear) count <= '0;
    else if (en && !expired) count <= count + W'(1);
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: MIPS write-back stage with load wait, timeout and retired counter
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = REG_BUS,
  parameter int RADDR_W = REG_ADDR_BUS,
  parameter int PC_W = INST_ADDR_BUS,
  parameter int TIMEOUT_CYC = WB_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_valid,
  input  logic               mem_RegWrite,
  input  logic               mem_MemtoReg,
  input  logic [RADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0]  mem_alu_result,
  input  logic [PC_W-1:0]    mem_pc,
  input  logic               dmem_rvalid,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               wb_stall,
  output logic               we,
  output logic [RADDR_W-1:0] waddr,
  output logic [DATA_W-1:0]  wdata,
  output logic [PC_W-1:0]    wb_pc,
  output logic               wb_err,
  output logic [31:0]        retired
);
  wb_state_e state, state_n;
  logic l_rw;
  logic [RADDR_W-1:0] l_waddr;
  logic [PC_W-1:0] l_pc;
  logic expired, commit_alu, start_ld, commit_ld, tmo;
  assign wb_stall = state == WB_WAIT;
  always_comb begin
    commit_alu = state == WB_IDLE && mem_valid && !mem_MemtoReg;
    start_ld = state == WB_IDLE && mem_valid && mem_MemtoReg;
    commit_ld = state == WB_WAIT && dmem_rvalid;
    tmo = state == WB_WAIT && !dmem_rvalid && expired;
    state_n = start_ld ? WB_WAIT : (commit_ld || tmo) ? WB_IDLE : state;
  end
  wb_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
    .clk(clk),
    .rst(rst),
    .clear(!wb_stall),
    .en(wb_stall),
    .expired(expired)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WB_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_rw <= 1'b0;
      l_waddr <= '0;
      l_pc <= '0;
    end else if (start_ld) begin
      l_rw <= mem_RegWrite;
      l_waddr <= mem_waddr;
      l_pc <= mem_pc;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      wb_pc <= '0;
      wb_err <= 1'b0;
      retired <= '0;
    end else begin
      we <= commit_alu ? mem_RegWrite && mem_waddr != '0 : commit_ld && l_rw && l_waddr != '0;
      if (commit_alu) begin
        waddr <= mem_waddr;
        wdata <= mem_alu_result;
        wb_pc <= mem_pc;
      end
      if (commit_ld) begin
        waddr <= l_waddr;
        wdata <= dmem_rdata;
        wb_pc <= l_pc;
      end
      if (commit_alu || commit_ld) retired <= retired + 32'd1;
      if (tmo) wb_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: vector table, corner sequences and random run against a reference model
module tb_wb_stage;
  localparam int TMO = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_valid, mem_RegWrite, mem_MemtoReg, dmem_rvalid;
  logic [4:0] mem_waddr;
  logic [31:0] mem_alu_result, mem_pc, dmem_rdata;
  logic wb_stall, we, wb_err;
  logic [4:0] waddr;
  logic [31:0] wdata, wb_pc, retired;
  int checks = 0;
  int passes = 0;
  wb_stage #(.DATA_W(32), .RADDR_W(5), .PC_W(32), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .mem_valid(mem_valid),
    .mem_RegWrite(mem_RegWrite),
    .mem_MemtoReg(mem_MemtoReg),
    .mem_waddr(mem_waddr),
    .mem_alu_result(mem_alu_result),
    .mem_pc(mem_pc),
    .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata),
    .wb_stall(wb_stall),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .wb_pc(wb_pc),
    .wb_err(wb_err),
    .retired(retired)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic v, mtr, rw;
    logic [4:0] wa;
    logic [31:0] alu, pc;
    logic rv;
    logic [31:0] rd;
    logic e_we;
    logic [4:0] e_wa;
    logic [31:0] e_wd, e_pc, e_ret;
    logic e_st;
  } vec_t;
  vec_t tbl[$];
  logic m_pend, m_we, m_err, l_rw;
  int m_cnt;
  logic [4:0] m_wa, l_wa;
  logic [31:0] m_wd, m_pc, m_ret, l_pc;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic drive(input logic v, mtr, rw, input logic [4:0] wa, input logic [31:0] alu, pc,
                       input logic rv, input logic [31:0] rd);
    mem_valid = v;
    mem_MemtoReg = mtr;
    mem_RegWrite = rw;
    mem_waddr = wa;
    mem_alu_result = alu;
    mem_pc = pc;
    dmem_rvalid = rv;
    dmem_rdata = rd;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic out_chk(input string t, input logic e_we, input logic [4:0] e_wa,
                         input logic [31:0] e_wd, e_pc, input logic e_err,
                         input logic [31:0] e_ret, input logic e_st);
    chk({t, ".we"}, 32'(we), 32'(e_we));
    chk({t, ".waddr"}, 32'(waddr), 32'(e_wa));
    chk({t, ".wdata"}, wdata, e_wd);
    chk({t, ".wb_pc"}, wb_pc, e_pc);
    chk({t, ".wb_err"}, 32'(wb_err), 32'(e_err));
    chk({t, ".retired"}, retired, e_ret);
    chk({t, ".stall"}, 32'(wb_stall), 32'(e_st));
  endtask
  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask
  task automatic m_commit(input logic rw, input logic [4:0] wa, input logic [31:0] d, pc);
    m_we = rw && wa != 0;
    m_wa = wa;
    m_wd = d;
    m_pc = pc;
    m_ret++;
  endtask
  task automatic model_step();
    if (!m_pend) begin
      if (mem_valid && !mem_MemtoReg) m_commit(mem_RegWrite, mem_waddr, mem_alu_result, mem_pc);
      else begin
        m_we = 0;
        if (mem_valid) begin
          m_pend = 1;
          m_cnt = 0;
          l_rw = mem_RegWrite;
          l_wa = mem_waddr;
          l_pc = mem_pc;
        end
      end
    end else if (dmem_rvalid) begin
      m_commit(l_rw, l_wa, dmem_rdata, l_pc);
      m_pend = 0;
    end else begin
      m_we = 0;
      m_cnt++;
      if (m_cnt == TMO) begin
        m_err = 1;
        m_pend = 0;
      end
    end
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    out_chk("reset", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tbl.push_back('{1, 0, 1, 5, 32'h1234, 32'h100, 0, 0, 1, 5, 32'h1234, 32'h100, 1, 0});
    tbl.push_back('{1, 0, 1, 0, 32'hFF, 32'h104, 0, 0, 0, 0, 32'hFF, 32'h104, 2, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h55, 0, 0, 32'hFF, 32'h104, 2, 0});
    tbl.push_back('{1, 0, 0, 7, 32'hAB, 32'h108, 0, 0, 0, 7, 32'hAB, 32'h108, 3, 0});
    tbl.push_back('{1, 1, 1, 8, 32'h999, 32'h10C, 0, 0, 0, 7, 32'hAB, 32'h108, 3, 1});
    tbl.push_back('{1, 0, 1, 9, 32'h77, 32'h110, 0, 0, 0, 7, 32'hAB, 32'h108, 3, 1});
    tbl.push_back('{1, 0, 1, 9, 32'h77, 32'h110, 0, 0, 0, 7, 32'hAB, 32'h108, 3, 1});
    tbl.push_back('{1, 0, 1, 9, 32'h77, 32'h110, 1, 32'hDEADBEEF, 1, 8, 32'hDEADBEEF, 32'h10C, 4, 0});
    tbl.push_back('{1, 0, 1, 9, 32'h77, 32'h110, 0, 0, 1, 9, 32'h77, 32'h110, 5, 0});
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].mtr, tbl[i].rw, tbl[i].wa, tbl[i].alu, tbl[i].pc, tbl[i].rv, tbl[i].rd);
      tick();
      out_chk($sformatf("vec%0d", i), tbl[i].e_we, tbl[i].e_wa, tbl[i].e_wd, tbl[i].e_pc, 0,
              tbl[i].e_ret, tbl[i].e_st);
    end
    do_reset();
    drive(1, 1, 1, 3, 0, 32'h200, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      out_chk($sformatf("tmo_wait%0d", i), 0, 0, 0, 0, 0, 0, 1);
    end
    tick();
    out_chk("tmo_hit", 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 32'h1111);
    tick();
    out_chk("tmo_late", 0, 0, 0, 0, 1, 0, 0);
    do_reset();
    drive(1, 1, 1, 9, 0, 32'h300, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    drive(0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D);
    tick();
    out_chk("edge_rv", 1, 9, 32'hCAFEF00D, 32'h300, 0, 1, 0);
    do_reset();
    drive(1, 1, 1, 4, 0, 32'h400, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    #1;
    out_chk("rst_wait", 0, 0, 0, 0, 0, 0, 0);
    #1;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1, 32'h4444);
    tick();
    out_chk("rst_late", 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 5'(i + 1), 32'(i * 3 + 10), 32'(i * 4 + 32'h500), 0, 0);
      tick();
      out_chk($sformatf("b2b%0d", i), 1, 5'(i + 1), 32'(i * 3 + 10), 32'(i * 4 + 32'h500), 0, 32'(i + 1), 0);
    end
    do_reset();
    m_pend = 0;
    m_we = 0;
    m_err = 0;
    m_cnt = 0;
    m_wa = 0;
    m_wd = 0;
    m_pc = 0;
    m_ret = 0;
    l_rw = 0;
    l_wa = 0;
    l_pc = 0;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 4) != 0,
            5'($urandom_range(0, 3) == 0 ? 0 : $urandom), $urandom, $urandom,
            $urandom_range(0, 3) == 0, $urandom);
      chk($sformatf("rnd%0d.stall_pre", i), 32'(wb_stall), 32'(m_pend));
      model_step();
      tick();
      out_chk($sformatf("rnd%0d", i), m_we, m_wa, m_wd, m_pc, m_err, m_ret, m_pend);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
